// File: rtl/booth_pkg.sv
// ============================================================================
// Module      : booth_pkg
// Description : Shared widths and types for the radix-4 Booth multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package booth_pkg;

    localparam int PP_W   = 16;
    localparam int PP_CNT = 4;

    typedef logic [PP_W-1:0] pp_t;

endpackage : booth_pkg

`default_nettype wire

// File: rtl/pp_add_stage.sv
// ============================================================================
// Module      : pp_add_stage
// Description : Registered two-operand modulo-2^W adder with valid/hold logic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pp_add_stage
    import booth_pkg::*;
#(
    parameter int W = PP_W
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         flush,
    input  logic         load,
    input  logic         drain,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         valid
);

    logic [W-1:0] r_sum;
    logic         r_valid;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_sum   <= '0;
            r_valid <= 1'b0;
        end else begin
            // Sum is only overwritten on load, so it holds while stalled.
            if (load) begin
                r_sum <= a + b;
            end
            r_valid <= !flush && (load || (r_valid && !drain));
        end
    end

    assign sum   = r_sum;
    assign valid = r_valid;

endmodule : pp_add_stage

`default_nettype wire

// File: rtl/pp_sum_pipe.sv
// ============================================================================
// Module      : pp_sum_pipe
// Description : Booth partial-product summation with valid/ready handshake.
//               PP_SUM_TWO_STAGE_EN selects the two-stage pipeline; when it is
//               undefined a single registered stage sums all four products.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pp_sum_pipe
    import booth_pkg::*;
#(
    parameter int W = PP_W
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         flush,
    input  logic [W-1:0] pp0,
    input  logic [W-1:0] pp1,
    input  logic [W-1:0] pp2,
    input  logic [W-1:0] pp3,
    input  logic         in_valid,
    output logic         in_ready,
    output logic [W-1:0] product,
    output logic         out_valid,
    input  logic         out_ready
);

    logic         w_in_ready;
    logic         w_adv1;
    logic         w_v2;
    logic [W-1:0] w_product;

`ifdef PP_SUM_TWO_STAGE_EN
    logic [W-1:0] w_s01;
    logic [W-1:0] w_s23;
    logic         w_v01;
    logic         w_v23;
    logic         w_v1;
    logic         w_adv2;

    // Both S1 lanes load together, so their valid flags always agree.
    assign w_v1       = w_v01 & w_v23;
    assign w_adv2     = w_v1 && (!w_v2 || out_ready);
    assign w_in_ready = !flush && (!w_v1 || !w_v2 || out_ready);
    assign w_adv1     = in_valid && w_in_ready;

    pp_add_stage #(.W(W)) u_s1_01 (
        .clk   (clk),
        .clr_n (clr_n),
        .flush (flush),
        .load  (w_adv1),
        .drain (w_adv2),
        .a     (pp0),
        .b     (pp1),
        .sum   (w_s01),
        .valid (w_v01)
    );

    pp_add_stage #(.W(W)) u_s1_23 (
        .clk   (clk),
        .clr_n (clr_n),
        .flush (flush),
        .load  (w_adv1),
        .drain (w_adv2),
        .a     (pp2),
        .b     (pp3),
        .sum   (w_s23),
        .valid (w_v23)
    );

    pp_add_stage #(.W(W)) u_s2 (
        .clk   (clk),
        .clr_n (clr_n),
        .flush (flush),
        .load  (w_adv2),
        .drain (out_ready),
        .a     (w_s01),
        .b     (w_s23),
        .sum   (w_product),
        .valid (w_v2)
    );
`else
    logic [W-1:0] w_sum01;
    logic [W-1:0] w_sum23;

    assign w_sum01    = pp0 + pp1;
    assign w_sum23    = pp2 + pp3;
    assign w_in_ready = !flush && (!w_v2 || out_ready);
    assign w_adv1     = in_valid && w_in_ready;

    pp_add_stage #(.W(W)) u_s2 (
        .clk   (clk),
        .clr_n (clr_n),
        .flush (flush),
        .load  (w_adv1),
        .drain (out_ready),
        .a     (w_sum01),
        .b     (w_sum23),
        .sum   (w_product),
        .valid (w_v2)
    );
`endif

    assign in_ready  = w_in_ready;
    assign product   = w_product;
    assign out_valid = w_v2;

endmodule : pp_sum_pipe

`default_nettype wire

// File: tb/tb_pp_sum_pipe.sv
// ============================================================================
// Module      : tb_pp_sum_pipe
// Description : Directed self-checking bench for pp_sum_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pp_sum_pipe;

    localparam int W = 16;
`ifdef PP_SUM_TWO_STAGE_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic         clk = 1'b0;
    logic         clr_n;
    logic         flush;
    logic [W-1:0] pp0, pp1, pp2, pp3;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] product;
    logic         out_valid;
    logic         out_ready;

    int n_cmp = 0;
    int n_err = 0;

    logic [W-1:0] sv [8][4];
    logic [W-1:0] se [8];

    always #5 clk = ~clk;

    pp_sum_pipe #(.W(W)) dut (
        .clk       (clk),
        .clr_n     (clr_n),
        .flush     (flush),
        .pp0       (pp0),
        .pp1       (pp1),
        .pp2       (pp2),
        .pp3       (pp3),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .product   (product),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] c, input logic [W-1:0] d, input logic v);
        pp0 = a; pp1 = b; pp2 = c; pp3 = d; in_valid = v;
    endtask

    initial begin
        int idx;
        int got;

        sv[0] = '{16'h0001, 16'h0002, 16'h0004, 16'h0008}; se[0] = 16'h000F;
        sv[1] = '{16'h1000, 16'h2000, 16'h3000, 16'h4000}; se[1] = 16'hA000;
        sv[2] = '{16'hFFFF, 16'h0001, 16'h0000, 16'h0000}; se[2] = 16'h0000;
        sv[3] = '{16'h7FFF, 16'h0001, 16'h0000, 16'h0000}; se[3] = 16'h8000;
        sv[4] = '{16'h0010, 16'h0020, 16'h0040, 16'h0080}; se[4] = 16'h00F0;
        sv[5] = '{16'hFFFC, 16'hFFF0, 16'hFFC0, 16'hFF00}; se[5] = 16'hFEAC;
        sv[6] = '{16'h1234, 16'h0000, 16'h0000, 16'h0000}; se[6] = 16'h1234;
        sv[7] = '{16'h8000, 16'h8000, 16'h8000, 16'h8000}; se[7] = 16'h0000;

        clr_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive('0, '0, '0, '0, 1'b0);

        // Reset state
        @(negedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_product", product, 16'h0000);
        check("rst_in_ready", in_ready, 1);
        clr_n = 1'b1;
        tick();

        // Booth 7 x (-3)
        out_ready = 1'b1;
        drive(16'h0007, 16'hFFE4, 16'h0000, 16'h0000, 1'b1);
        #1;
        check("booth_in_ready", in_ready, 1);
        tick();
        drive('0, '0, '0, '0, 1'b0);
        check("booth_early_valid", out_valid, (LAT == 1) ? 1 : 0);
        repeat (LAT - 1) tick();
        check("booth_out_valid", out_valid, 1);
        check("booth_product", product, 16'hFFEB);
        tick();
        check("booth_consumed", out_valid, 0);

        // Wrap-around
        drive(16'h8000, 16'h8000, 16'h0001, 16'h0000, 1'b1);
        tick();
        drive('0, '0, '0, '0, 1'b0);
        repeat (LAT - 1) tick();
        check("wrap_out_valid", out_valid, 1);
        check("wrap_product", product, 16'h0001);
        tick();

        // Streaming, no bubbles
        for (int c = 0; c < 8 + LAT; c++) begin
            if (c < 8) drive(sv[c][0], sv[c][1], sv[c][2], sv[c][3], 1'b1);
            else       in_valid = 1'b0;
            #1;
            if (c < 8) check("stream_in_ready", in_ready, 1);
            if (c >= LAT) begin
                check("stream_out_valid", out_valid, 1);
                check("stream_product", product, se[c - LAT]);
            end
            tick();
        end
        check("stream_drained", out_valid, 0);

        // Back-pressure
        out_ready = 1'b0;
        idx = 0;
        for (int c = 0; c < 5; c++) begin
            drive(sv[idx][0], sv[idx][1], sv[idx][2], sv[idx][3], 1'b1);
            #1;
            if (c >= LAT) begin
                check("bp_hold_valid", out_valid, 1);
                check("bp_hold_product", product, se[0]);
            end
            if (in_ready) idx++;
            tick();
        end
        check("bp_accepts", idx, LAT);
        check("bp_in_ready_low", in_ready, 0);
        in_valid = 1'b0;
        out_ready = 1'b1;
        got = 0;
        for (int c = 0; c < 5; c++) begin
            #1;
            if (out_valid) begin
                check("bp_drain_product", product, se[got]);
                got++;
            end
            tick();
        end
        check("bp_drain_count", got, LAT);

        // Flush with a full pipe
        out_ready = 1'b0;
        for (int c = 0; c < LAT; c++) begin
            drive(sv[4 + c][0], sv[4 + c][1], sv[4 + c][2], sv[4 + c][3], 1'b1);
            #1;
            check("fl_fill_ready", in_ready, 1);
            tick();
        end
        check("fl_full_valid", out_valid, 1);
        flush = 1'b1;
        drive(sv[3][0], sv[3][1], sv[3][2], sv[3][3], 1'b1);
        #1;
        check("fl_in_ready", in_ready, 0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        check("fl_cleared", out_valid, 0);
        out_ready = 1'b1;
        repeat (LAT + 1) tick();
        check("fl_empty", out_valid, 0);

        // Flush blocks input on an otherwise idle, ready pipe
        flush = 1'b1;
        drive(sv[1][0], sv[1][1], sv[1][2], sv[1][3], 1'b1);
        #1;
        check("fl_idle_in_ready", in_ready, 0);
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        repeat (LAT) tick();
        check("fl_idle_no_accept", out_valid, 0);

        // Asynchronous reset with a result pending
        out_ready = 1'b0;
        drive(16'h0007, 16'hFFE4, 16'h0000, 16'h0000, 1'b1);
        tick();
        in_valid = 1'b0;
        repeat (LAT - 1) tick();
        check("ar_pending_valid", out_valid, 1);
        check("ar_pending_product", product, 16'hFFEB);
        #2;
        clr_n = 1'b0;
        #1;
        check("ar_out_valid", out_valid, 0);
        check("ar_product", product, 16'h0000);
        @(negedge clk);
        clr_n = 1'b1;
        tick();
        check("ar_after", out_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_pp_sum_pipe

`default_nettype wire
